// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle between the user logic and the 7-segment scanner.
// The master drives the display value; the slave drives the board pins.
interface seven_seg_scanner_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic        load;
    logic        pending;
    logic        frame_start;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    modport master (
        output value, dp_in, en_in, load,
        input  pending, frame_start, seg, dp, an
    );

    modport slave (
        input  value, dp_in, en_in, load,
        output pending, frame_start, seg, dp, an
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Round-robin scanner for a 4-digit common-anode 7-segment display with
// anode dead-time and a frame-synchronous double-buffered display value.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input logic                clock,
    input logic                reset,
    seven_seg_scanner_if.slave bus
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_t;

    function automatic logic [6:0] hex(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    disp_t         pbuf_q, pbuf_d;
    disp_t         abuf_q, abuf_d;
    logic          pending_q, pending_d;
    logic          fs_q, fs_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          wrap, boundary, blank;
    logic [3:0]    nib;
    disp_t         din;

    always_comb begin
        din      = '{value: bus.value, dp: bus.dp_in, en: bus.en_in};
        wrap     = (cnt_q == LAST);
        boundary = wrap && (idx_q == 2'd3);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;

        pbuf_d    = bus.load ? din : pbuf_q;
        abuf_d    = abuf_q;
        pending_d = pending_q;
        // A load landing on the boundary goes straight to the active buffer
        if (boundary) begin
            abuf_d    = bus.load ? din : pbuf_q;
            pending_d = 1'b0;
        end else if (bus.load) begin
            pending_d = 1'b1;
        end

        blank = (32'(cnt_q) < BLANK_CYCLES);
        nib   = abuf_q.value[{idx_q, 2'b00} +: 4];
        fs_d  = (cnt_q == '0) && (idx_q == 2'd0);

        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!blank && abuf_q.en[idx_q]) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = ~hex(nib);
            dp_d  = ~abuf_q.dp[idx_q];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pbuf_q    <= '0;
            abuf_q    <= '0;
            pending_q <= 1'b0;
            fs_q      <= 1'b0;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            an_q      <= 4'hF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pbuf_q    <= pbuf_d;
            abuf_q    <= abuf_d;
            pending_q <= pending_d;
            fs_q      <= fs_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign bus.pending     = pending_q;
    assign bus.frame_start = fs_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at REFRESH_DIV=8, BLANK_CYCLES=2
// (32-cycle frame), with hand-computed segment patterns.
module tb_seven_seg_scanner;

    localparam int RD = 8;
    localparam int BC = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seven_seg_scanner_if bus();

    seven_seg_scanner #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int t     = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
        t++;
    endtask

    task automatic load_v(input logic [15:0] v, input logic [3:0] d,
                          input logic [3:0] e);
        bus.value = v;
        bus.dp_in = d;
        bus.en_in = e;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    // segs[7d+:7] = expected active-low seg for digit d, dps[d] = expected dp pin
    task automatic check_frame(input string tag, input logic [27:0] segs,
                               input logic [3:0] dps, input logic [3:0] en);
        for (int p = 0; p < 32; p++) begin
            int d = p / 8;
            int c = p % 8;
            logic [3:0] ea;
            logic [6:0] es;
            logic       ed;
            tick();
            if (c < BC || !en[d]) begin
                ea = 4'hF;
                es = 7'h7F;
                ed = 1'b1;
            end else begin
                ea = ~(4'b0001 << d);
                es = segs[7*d +: 7];
                ed = dps[d];
            end
            chk($sformatf("%s an p%0d", tag, p), bus.an, ea);
            chk($sformatf("%s seg p%0d", tag, p), bus.seg, es);
            chk($sformatf("%s dp p%0d", tag, p), bus.dp, ed);
            chk($sformatf("%s fs p%0d", tag, p), bus.frame_start, p == 0);
        end
    endtask

    initial begin
        bus.value = '0;
        bus.dp_in = '0;
        bus.en_in = '0;
        bus.load  = 1'b0;

        repeat (3) tick();
        chk("rst an", bus.an, 4'hF);
        chk("rst seg", bus.seg, 7'h7F);
        chk("rst dp", bus.dp, 1'b1);
        chk("rst pending", bus.pending, 1'b0);
        chk("rst fs", bus.frame_start, 1'b0);
        reset = 1'b0;
        t = 0;

        check_frame("dark0", 28'h0, 4'hF, 4'h0);
        check_frame("dark1", 28'h0, 4'hF, 4'h0);

        load_v(16'h1234, 4'b0100, 4'b1111);
        chk("1234 pending set", bus.pending, 1'b1);
        repeat (30) tick();
        chk("1234 pending hold", bus.pending, 1'b1);
        tick();
        chk("1234 pending clr", bus.pending, 1'b0);
        check_frame("1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011, 4'hF);

        repeat (31) tick();
        load_v(16'hABCD, 4'b0000, 4'b1111);
        chk("abcd bypass pending", bus.pending, 1'b0);
        check_frame("abcd", {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 4'hF);

        repeat (3) tick();
        load_v(16'h0001, 4'b0000, 4'b1111);
        chk("0001 pending", bus.pending, 1'b1);
        repeat (4) tick();
        load_v(16'hFFFF, 4'b1111, 4'b0101);
        chk("ffff pending", bus.pending, 1'b1);
        repeat (23) tick();
        chk("ffff pending clr", bus.pending, 1'b0);
        check_frame("ffff", {4{7'h0E}}, 4'b0000, 4'b0101);

        repeat (21) tick();
        chk("pre-rst an", bus.an, 4'b1011);
        chk("pre-rst seg", bus.seg, 7'h0E);
        reset = 1'b1;
        tick();
        chk("midrst an", bus.an, 4'hF);
        chk("midrst seg", bus.seg, 7'h7F);
        chk("midrst dp", bus.dp, 1'b1);
        chk("midrst pending", bus.pending, 1'b0);
        reset = 1'b0;
        t = 0;
        check_frame("post-rst", 28'h0, 4'hF, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
